// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: 3-slot destination scoreboard, forwarding select,
// load-use / no-bypass stall generation, branch flush and a halt drain FSM.
module pipe_hazard_ctrl #(
  parameter int FORWARD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_br_taken,
  output logic        if_stall,
  output logic        id_stall,
  output logic        flush,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] dst;
    logic       ld;
  } slot_t;

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  slot_t       ex_q, mem_q, wb_q, ex_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       op_wr_s, op_ld_s, op_halt_s, use_rs_s, use_rt_s;
  logic [4:0] dest_s;
  logic       rs_ex_s, rs_mem_s, rs_wb_s, rt_ex_s, rt_mem_s, rt_wb_s;
  logic       haz_s, stall_s, issue_s;

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.v && s.wr && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] youngest(input logic e, input logic m, input logic w);
    if (e)      return 2'd1;
    else if (m) return 2'd2;
    else if (w) return 2'd3;
    else        return 2'd0;
  endfunction

  always_comb begin
    op_wr_s   = (id_opcode <= 6'd12);
    op_ld_s   = (id_opcode == 6'd12);
    op_halt_s = (id_opcode == 6'd17);
    dest_s    = ((id_opcode <= 6'd10) && !id_opcode[0]) ? id_rd : id_rt;
    use_rs_s  = id_valid && (id_opcode <= 6'd16);
    use_rt_s  = id_valid && (((id_opcode <= 6'd10) && !id_opcode[0]) ||
                             (id_opcode == 6'd13) || (id_opcode == 6'd15));
    rs_ex_s   = use_rs_s && slot_hit(ex_q,  id_rs);
    rs_mem_s  = use_rs_s && slot_hit(mem_q, id_rs);
    rs_wb_s   = use_rs_s && slot_hit(wb_q,  id_rs);
    rt_ex_s   = use_rt_s && slot_hit(ex_q,  id_rt);
    rt_mem_s  = use_rt_s && slot_hit(mem_q, id_rt);
    rt_wb_s   = use_rt_s && slot_hit(wb_q,  id_rt);
    if (FORWARD != 0) begin
      haz_s      = (rs_ex_s || rt_ex_s) && ex_q.ld;
      fwd_rs_sel = youngest(rs_ex_s, rs_mem_s, rs_wb_s);
      fwd_rt_sel = youngest(rt_ex_s, rt_mem_s, rt_wb_s);
    end else begin
      // Without bypass the regfile covers WB only; EX and MEM producers must drain.
      haz_s      = rs_ex_s || rs_mem_s || rt_ex_s || rt_mem_s;
      fwd_rs_sel = 2'd0;
      fwd_rt_sel = 2'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_s = haz_s && !ex_br_taken;
        if (id_valid && op_halt_s && !stall_s && !ex_br_taken) begin
          state_d = ST_DRAIN;
          drain_d = 2'd2;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        stall_s = 1'b1;
        if (drain_q == 2'd0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      ST_HALTED: begin
        stall_s = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    issue_s = (state_q == ST_RUN) && id_valid && !stall_s && !ex_br_taken;
    ex_d    = '0;
    if (issue_s) begin
      ex_d.v   = 1'b1;
      ex_d.wr  = op_wr_s;
      ex_d.dst = dest_s;
      ex_d.ld  = op_ld_s;
    end else begin
      ex_d = '0;
    end
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_stall  = stall_s;
  assign if_stall  = stall_s;
  assign flush     = ex_br_taken;
  assign halted    = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;

endmodule
